// File: rtl/master_port_if.sv
// Serial system-bus signals between one master port and one slave port.
interface master_port_if;
   logic mode;
   logic wr_bus;
   logic master_valid;
   logic slave_ready;
   logic rd_bus;
   logic slave_valid;
   logic master_ready;

   modport master (
      output mode, wr_bus, master_valid, master_ready,
      input  slave_ready, rd_bus, slave_valid
   );

   modport slave (
      input  mode, wr_bus, master_valid, master_ready,
      output slave_ready, rd_bus, slave_valid
   );
endinterface

// File: rtl/master_port.sv
// Serial bus initiator: shifts {addr, wdata} out MSB-first, optionally collects
// a serial read return, then issues a one-cycle parallel response.
module master_port #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_mode,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   master_port_if.master         bus
);
   localparam int FW = ADDR_WIDTH + DATA_WIDTH;
   localparam int BW = $clog2(FW + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {IDLE, SHIFT, TRAIL, RD_WAIT, RD_DATA, RESP} state_t;

   state_t                state, state_nxt;
   logic [FW-1:0]         sh;
   logic                  mode_q;
   logic [BW-1:0]         bit_cnt;
   logic [TW-1:0]         tmo_cnt;
   logic [RW-1:0]         rd_cnt;
   logic [DATA_WIDTH-1:0] rd_sh;
   logic                  err_q;
   logic                  err_nxt;
   logic                  xfer;
   logic                  rd_take;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      xfer      = 1'b0;
      rd_take   = 1'b0;
      case (state)
         IDLE:    if (req_valid) state_nxt = SHIFT;
         // Bit 0 goes out unconditionally: the slave latches it while leaving idle.
         SHIFT: begin
            if (bit_cnt == '0 || bus.slave_ready) begin
               xfer = 1'b1;
               if (bit_cnt == BW'(FW - 1)) state_nxt = TRAIL;
            end else begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end
         end
         TRAIL: begin
            if (!bus.slave_ready) begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end else if (mode_q) state_nxt = RESP;
            else                 state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.slave_valid) begin
               rd_take   = 1'b1;
               state_nxt = RD_DATA;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end
         end
         RD_DATA: begin
            if (bus.slave_valid) begin
               rd_take = 1'b1;
               if (rd_cnt == RW'(DATA_WIDTH - 1)) state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh      <= '0;
         mode_q  <= 1'b0;
         bit_cnt <= '0;
         tmo_cnt <= '0;
         rd_cnt  <= '0;
         rd_sh   <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= err_nxt;
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               tmo_cnt <= '0;
               rd_cnt  <= '0;
               if (req_valid) begin
                  sh     <= {req_addr, req_wdata};
                  mode_q <= req_mode;
                  rd_sh  <= '0;
               end
            end
            SHIFT: begin
               if (xfer) begin
                  sh      <= sh << 1;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            RD_WAIT: if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
            default: ;
         endcase
         // Read data accumulates in place; it stays 0 for writes, aborts and timeouts.
         if (rd_take) begin
            rd_sh  <= {rd_sh[DATA_WIDTH-2:0], bus.rd_bus};
            rd_cnt <= rd_cnt + 1'b1;
         end
      end
   end

   assign req_ready        = (state == IDLE) && !rst;
   assign rsp_valid        = (state == RESP);
   assign rsp_err          = err_q;
   assign rsp_rdata        = rd_sh;
   assign bus.master_valid = (state == SHIFT) || (state == TRAIL);
   assign bus.mode         = bus.master_valid && mode_q;
   assign bus.wr_bus       = (state == SHIFT) && sh[FW-1];
   assign bus.master_ready = (state == RD_WAIT) || (state == RD_DATA);
endmodule

// File: tb/tb_master_port.sv
// Self-checking bench for master_port: directed and randomized transactions
// against a cycle-count reference model of the serial bus frame.
module tb_master_port;
   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_mode;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [7:0]  rsp_rdata;

   int checks = 0;
   int errors = 0;

   master_port_if bus();

   master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_mode  (req_mode),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Runs one request starting from an IDLE negedge and ends on the IDLE negedge
   // after RESP. drop: bit index (1..23) or 24 (trailer) where slave_ready goes low,
   // -1 for none. dly: idle cycles after trailer before slave_valid, >=64 never.
   // Read return stalls st_len cycles after bit st_after has been sent.
   task automatic run_txn(input bit wr, input logic [15:0] a, input logic [7:0] d,
                          input int drop, input int dly, input logic [7:0] rdat,
                          input int st_after, input int st_len, input bit r0);
      logic [23:0] fb;
      logic [5:0]  exp_v, got_v;
      int          end_n, s, j, bi;
      bit          exp_err, sv, rb;
      fb = {a, d};
      s  = 26 + dly;
      if (drop >= 1) begin
         end_n = drop + 2; exp_err = 1'b1;
      end else if (wr) begin
         end_n = 26; exp_err = 1'b0;
      end else if (dly >= 64) begin
         end_n = 90; exp_err = 1'b1;
      end else begin
         end_n = s + 8 + st_len; exp_err = 1'b0;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready got=%b exp=1", req_ready);
      end
      req_valid = 1'b1; req_mode = wr; req_addr = a; req_wdata = d;
      bus.slave_ready = 1'b0; bus.slave_valid = 1'b0; bus.rd_bus = 1'b0;
      for (int n = 1; n <= end_n + 1; n++) begin
         @(negedge clk);
         if (n < end_n)
            exp_v = {1'b0, (n <= 25), (n <= 24) ? fb[24 - n] : 1'b0, wr && (n <= 25),
                     !wr && (drop < 1) && (n >= 26), 1'b0};
         else if (n == end_n) exp_v = 6'b000001;
         else                 exp_v = 6'b100000;
         got_v = {req_ready, bus.master_valid, bus.wr_bus, bus.mode, bus.master_ready, rsp_valid};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL cycle wr=%0d addr=%h n=%0d {rdy,mv,wb,mode,mr,rv} got=%b exp=%b",
                     wr, a, n, got_v, exp_v);
         end
         if (n == end_n) begin
            checks++;
            if (rsp_err !== exp_err) begin
               errors++;
               $display("FAIL rsp_err wr=%0d addr=%h got=%b exp=%b", wr, a, rsp_err, exp_err);
            end
            if (!wr && drop < 1) begin
               checks++;
               if (rsp_rdata !== ((dly >= 64) ? 8'h00 : rdat)) begin
                  errors++;
                  $display("FAIL rsp_rdata addr=%h got=%h exp=%h", a, rsp_rdata,
                           (dly >= 64) ? 8'h00 : rdat);
               end
            end
         end
         // inputs for the edge closing cycle n
         req_valid = 1'b0;
         req_mode  = 1'($urandom);
         req_addr  = 16'($urandom);
         req_wdata = 8'($urandom);
         if (n == 1)       bus.slave_ready = r0;
         else if (n <= 25) bus.slave_ready = (n != drop + 1);
         else              bus.slave_ready = 1'($urandom);
         sv = 1'b0;
         rb = 1'($urandom);
         if (n <= 25) sv = 1'($urandom);
         else if (!wr && drop < 1 && dly < 64 && n < end_n) begin
            j = n - s;
            if (j >= 0 && !(st_len > 0 && j > st_after && j <= st_after + st_len)) begin
               bi = (st_len > 0 && j > st_after) ? j - st_len : j;
               if (bi < 8) begin
                  sv = 1'b1;
                  rb = rdat[7 - bi];
               end
            end
         end
         bus.slave_valid = sv;
         bus.rd_bus      = rb;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, bus.master_valid, bus.wr_bus, bus.mode, bus.master_ready,
           rsp_valid, rsp_err} !== 7'b0 || rsp_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got=%b rdata=%h exp=all zero",
                  {req_ready, bus.master_valid, bus.wr_bus, bus.mode, bus.master_ready,
                   rsp_valid, rsp_err}, rsp_rdata);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got=%b exp=1", req_ready);
      end
   endtask

   task automatic test_write();
      run_txn(1'b1, 16'h1234, 8'hA5, -1, 0, 8'h00, -1, 0, 1'b0);
   endtask

   task automatic test_read();
      run_txn(1'b0, 16'h00FF, 8'h00, -1, 2, 8'h3C, -1, 0, 1'b1);
   endtask

   task automatic test_abort();
      run_txn(1'b1, 16'($urandom), 8'($urandom), 10, 0, 8'h00, -1, 0, 1'b1);
      run_txn(1'b1, 16'($urandom), 8'($urandom), 1, 0, 8'h00, -1, 0, 1'b0);
      run_txn(1'b0, 16'($urandom), 8'($urandom), 24, 0, 8'h00, -1, 0, 1'b1);
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 16'($urandom), 8'($urandom), -1, 64, 8'h00, -1, 0, 1'b1);
      run_txn(1'b0, 16'($urandom), 8'($urandom), -1, 63, 8'hC3, -1, 0, 1'b1);
   endtask

   task automatic test_read_stall();
      run_txn(1'b0, 16'($urandom), 8'($urandom), -1, 1, 8'h81, 3, 2, 1'b1);
   endtask

   task automatic test_rst_mid();
      logic [23:0] fb;
      fb = {16'hBEEF, 8'h5A};
      req_valid = 1'b1; req_mode = 1'b1; req_addr = 16'hBEEF; req_wdata = 8'h5A;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         checks++;
         if ({bus.master_valid, bus.wr_bus} !== {1'b1, fb[24 - n]}) begin
            errors++;
            $display("FAIL rst_mid_frame n=%0d {mv,wb} got=%b exp=%b", n,
                     {bus.master_valid, bus.wr_bus}, {1'b1, fb[24 - n]});
         end
         req_valid = 1'b0;
         bus.slave_ready = (n >= 2);
         if (n == 6) rst = 1'b1;
      end
      @(negedge clk);
      checks++;
      if ({req_ready, bus.master_valid, bus.mode, rsp_valid} !== 4'b0) begin
         errors++;
         $display("FAIL rst_mid_state {rdy,mv,mode,rv} got=%b exp=0000",
                  {req_ready, bus.master_valid, bus.mode, rsp_valid});
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_ready got=%b exp=1", req_ready);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({req_ready, bus.master_valid, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_idle {rdy,mv,rv} got=%b exp=100",
                     {req_ready, bus.master_valid, rsp_valid});
         end
      end
      run_txn(1'b1, 16'h0F0F, 8'h33, -1, 0, 8'h00, -1, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         bit          wr;
         int          stl, sta;
         wr  = 1'($urandom);
         stl = int'($urandom_range(0, 3));
         sta = int'($urandom_range(0, 6));
         run_txn(wr, 16'($urandom), 8'($urandom), -1, int'($urandom_range(0, 20)),
                 8'($urandom), sta, stl, 1'($urandom));
      end
      run_txn(1'($urandom), 16'($urandom), 8'($urandom), int'($urandom_range(1, 24)), 0,
              8'h00, -1, 0, 1'($urandom));
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_mode = 1'b0; req_addr = '0; req_wdata = '0;
      bus.slave_ready = 1'b0; bus.slave_valid = 1'b0; bus.rd_bus = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_timeout();
      test_read_stall();
      test_rst_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
